// File: rtl/mem_node_if.sv
// Neighbour-side bundle of a mem_node: push handshake (rready/in_data/read),
// offer handshake (write/wready/out) and status; the node uses the slave modport.
interface mem_node_if #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 11,
    parameter int DEPTH  = 15
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NPORTS-1:0]        rready;
    logic [NPORTS*DATA_W-1:0] in_data;
    logic [NPORTS-1:0]        read;
    logic [NPORTS-1:0]        write;
    logic [NPORTS-1:0]        wready;
    logic [DATA_W-1:0]        out;
    logic [CW-1:0]            count;
    logic                     empty;
    logic                     full;
    logic                     collide;

    modport master (
        output rready, in_data, wready,
        input  read, write, out, count, empty, full, collide
    );

    modport slave (
        input  rready, in_data, wready,
        output read, write, out, count, empty, full, collide
    );
endinterface

// File: rtl/mem_node.sv
// TIS memory node: LIFO/FIFO store fed by round-robin push arbitration, offered back broadcast or round-robin.
// Push acked one cycle after rready; offer appears two cycles after first push; a pop leaves a one-cycle bubble; full blocks pushes unless popping.
module mem_node #(
    parameter int                DATA_W    = 11,
    parameter int                DEPTH     = 15,
    parameter int                NPORTS    = 4,
    parameter logic [NPORTS-1:0] PORT_MASK = '1,
    parameter bit                QUEUE     = 1'b0,
    parameter bit                RR_OFFER  = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    mem_node_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     head, tail;
    logic [NPORTS-1:0] read_q, write_q;
    logic [IW-1:0]     push_ptr, offer_ptr;
    logic              collide_q;

    logic [NPORTS-1:0] cand, hits, write_nxt;
    logic              pop, multi, push, offer_ok, found;
    logic [IW-1:0]     push_port, offer_base, offer_sel;
    logic [DATA_W-1:0] push_dat;
    logic [CW-1:0]     cnt_m1;
    logic [PW-1:0]     top_idx, wr_idx;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        cand  = bus.rready & PORT_MASK & ~read_q;
        hits  = bus.wready & write_q;
        pop   = |hits;
        multi = (hits & (hits - NPORTS'(1))) != '0;

        push      = 1'b0;
        push_port = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!push && cand[(int'(push_ptr) + i) % NPORTS]) begin
                push      = 1'b1;
                push_port = IW'((int'(push_ptr) + i) % NPORTS);
            end
        end
        // A full store only accepts when the same edge frees a slot.
        if (cnt == CW'(DEPTH) && !pop) push = 1'b0;
        push_dat = bus.in_data[int'(push_port)*DATA_W +: DATA_W];

        cnt_m1  = cnt - CW'(1);
        top_idx = QUEUE ? head : cnt_m1[PW-1:0];
        wr_idx  = QUEUE ? tail : (pop ? cnt_m1[PW-1:0] : cnt[PW-1:0]);

        offer_base = (write_q != '0) ? IW'((int'(offer_ptr) + 1) % NPORTS) : offer_ptr;
        offer_sel  = offer_base;
        found      = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && PORT_MASK[(int'(offer_base) + i) % NPORTS]) begin
                found     = 1'b1;
                offer_sel = IW'((int'(offer_base) + i) % NPORTS);
            end
        end

        // A LIFO push replaces the top, so withdraw the offer for a cycle.
        offer_ok = (cnt != '0) && !pop && (QUEUE || !push);
        if (!offer_ok)     write_nxt = '0;
        else if (RR_OFFER) write_nxt = NPORTS'(1) << offer_sel;
        else               write_nxt = PORT_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            head      <= '0;
            tail      <= '0;
            read_q    <= '0;
            write_q   <= '0;
            push_ptr  <= '0;
            offer_ptr <= '0;
            collide_q <= 1'b0;
        end else begin
            read_q    <= push ? (NPORTS'(1) << push_port) : '0;
            write_q   <= write_nxt;
            offer_ptr <= offer_sel;
            if (multi) collide_q <= 1'b1;
            if (push) push_ptr <= IW'((int'(push_port) + 1) % NPORTS);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (!push && pop) cnt <= cnt_m1;
            if (QUEUE) begin
                if (push) tail <= inc(tail);
                if (pop)  head <= inc(head);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_idx] <= push_dat;
    end

    assign bus.read    = read_q;
    assign bus.write   = write_q;
    assign bus.out     = (cnt == '0) ? '0 : mem[top_idx];
    assign bus.count   = cnt;
    assign bus.empty   = (cnt == '0);
    assign bus.full    = (cnt == CW'(DEPTH));
    assign bus.collide = collide_q;
endmodule

// File: tb/tb_mem_node.sv
// Bench for mem_node: LIFO, small FIFO and round-robin instances share one stimulus stream
// and are compared every cycle against a queue-based model, plus directed scenario checks.
module tb_mem_node;
    localparam int N = 4;
    localparam int W = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   rr  = '0;
    logic [N*W-1:0] din = '0;
    logic [N-1:0]   wr  = '0;

    mem_node_if #(.NPORTS(N), .DATA_W(W), .DEPTH(15)) b0 ();
    mem_node_if #(.NPORTS(N), .DATA_W(W), .DEPTH(4))  b1 ();
    mem_node_if #(.NPORTS(N), .DATA_W(W), .DEPTH(15)) b2 ();

    assign b0.rready = rr;  assign b0.in_data = din;  assign b0.wready = wr;
    assign b1.rready = rr;  assign b1.in_data = din;  assign b1.wready = wr;
    assign b2.rready = rr;  assign b2.in_data = din;  assign b2.wready = wr;

    mem_node #(.DATA_W(W), .DEPTH(15), .NPORTS(N), .PORT_MASK(4'b1111), .QUEUE(1'b0), .RR_OFFER(1'b0))
        u_lifo (.clk(clk), .rst(rst), .bus(b0.slave));
    mem_node #(.DATA_W(W), .DEPTH(4), .NPORTS(N), .PORT_MASK(4'b1111), .QUEUE(1'b1), .RR_OFFER(1'b0))
        u_fifo (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_node #(.DATA_W(W), .DEPTH(15), .NPORTS(N), .PORT_MASK(4'b1010), .QUEUE(1'b0), .RR_OFFER(1'b1))
        u_rr (.clk(clk), .rst(rst), .bus(b2.slave));

    int cfg_depth [3] = '{15, 4, 15};
    int cfg_mask  [3] = '{15, 15, 10};
    bit cfg_q     [3] = '{1'b0, 1'b1, 1'b0};
    bit cfg_rr    [3] = '{1'b0, 1'b0, 1'b1};

    // Reference: stored words as a plain list (back = LIFO top, front = FIFO head).
    int mq [3][$];
    int m_read [3], m_write [3], m_pptr [3], m_optr [3];
    bit m_col [3];

    int o_write [3], o_read [3], o_out [3], o_count [3], o_empty [3], o_full [3], o_col [3];
    int got [$];
    int got_cyc [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int next_en(input int k, input int from);
        for (int i = 0; i < N; i++)
            if (((cfg_mask[k] >> ((from + i) % N)) & 1) != 0) return (from + i) % N;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_read[k] = 0; m_write[k] = 0; m_pptr[k] = 0; m_optr[k] = 0; m_col[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int hits, cand, sz, d, v;
            bit pop, push, ok;
            hits = int'(wr) & m_write[k];
            pop  = (hits != 0);
            if ($countones(hits) >= 2) m_col[k] = 1'b1;
            cand = int'(rr) & cfg_mask[k] & ~m_read[k];
            sz   = mq[k].size();
            push = 1'b0;
            d    = 0;
            if (cand != 0 && (sz < cfg_depth[k] || pop))
                for (int i = 0; i < N; i++)
                    if (!push && ((cand >> ((m_pptr[k] + i) % N)) & 1) != 0) begin
                        push = 1'b1;
                        d    = (m_pptr[k] + i) % N;
                    end
            v  = int'(din[d*W +: W]);
            ok = (sz > 0) && !pop && (cfg_q[k] || !push);
            if (pop) begin
                if (cfg_q[k]) void'(mq[k].pop_front());
                else          void'(mq[k].pop_back());
            end
            if (push) begin
                mq[k].push_back(v);
                m_pptr[k] = (d + 1) % N;
            end
            if (cfg_rr[k])
                m_optr[k] = (m_write[k] != 0) ? next_en(k, (m_optr[k] + 1) % N) : next_en(k, m_optr[k]);
            m_write[k] = ok ? (cfg_rr[k] ? (1 << m_optr[k]) : cfg_mask[k]) : 0;
            m_read[k]  = push ? (1 << d) : 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int sz, eo;
            case (k)
                0: begin
                    o_write[k] = int'(b0.write); o_read[k] = int'(b0.read); o_out[k] = int'(b0.out);
                    o_count[k] = int'(b0.count); o_empty[k] = int'(b0.empty); o_full[k] = int'(b0.full);
                    o_col[k] = int'(b0.collide);
                end
                1: begin
                    o_write[k] = int'(b1.write); o_read[k] = int'(b1.read); o_out[k] = int'(b1.out);
                    o_count[k] = int'(b1.count); o_empty[k] = int'(b1.empty); o_full[k] = int'(b1.full);
                    o_col[k] = int'(b1.collide);
                end
                default: begin
                    o_write[k] = int'(b2.write); o_read[k] = int'(b2.read); o_out[k] = int'(b2.out);
                    o_count[k] = int'(b2.count); o_empty[k] = int'(b2.empty); o_full[k] = int'(b2.full);
                    o_col[k] = int'(b2.collide);
                end
            endcase
            sz = mq[k].size();
            eo = (sz == 0) ? 0 : (cfg_q[k] ? mq[k][0] : mq[k][sz-1]);
            chk($sformatf("k%0d.write", k),   o_write[k], m_write[k]);
            chk($sformatf("k%0d.read", k),    o_read[k],  m_read[k]);
            chk($sformatf("k%0d.out", k),     o_out[k],   eo);
            chk($sformatf("k%0d.count", k),   o_count[k], sz);
            chk($sformatf("k%0d.empty", k),   o_empty[k], int'(sz == 0));
            chk($sformatf("k%0d.full", k),    o_full[k],  int'(sz == cfg_depth[k]));
            chk($sformatf("k%0d.collide", k), o_col[k],   int'(m_col[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; rr = '0; wr = '0; din = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_one(input int p, input int v);
        rr[p] = 1'b1;
        din[p*W +: W] = W'(v);
        tick();
        rr = '0;
        tick();
    endtask

    task automatic take(input int k, input int p, input int n);
        got.delete();
        got_cyc.delete();
        wr[p] = 1'b1;
        for (int c = 0; c < 60 && got.size() < n; c++) begin
            if (((o_write[k] >> p) & 1) != 0) begin
                got.push_back(o_out[k]);
                got_cyc.push_back(c);
            end
            tick();
        end
        wr = '0;
        chk("take.n", got.size(), n);
    endtask

    task automatic wait_write(input int k);
        for (int c = 0; c < 30 && o_write[k] == 0; c++) tick();
        chk("wait.write", int'(o_write[k] != 0), 1);
    endtask

    initial begin
        int w [4];
        int exp_f [4];

        // Reset and idle
        do_reset();
        tick();
        chk("idle.write", o_write[0], 0);
        chk("idle.read", o_read[0], 0);
        chk("idle.out", o_out[0], 0);
        chk("idle.count", o_count[0], 0);
        chk("idle.empty", o_empty[0], 1);
        chk("idle.collide", o_col[0], 0);

        // LIFO order with bubbles
        do_reset();
        for (int v = 1; v <= 3; v++) push_one(3, v);
        take(0, 1, 3);
        for (int i = 0; i < got.size(); i++) chk("lifo.val", got[i], 3 - i);
        for (int i = 1; i < got.size(); i++) chk("lifo.gap", got_cyc[i] - got_cyc[i-1], 2);
        chk("lifo.count", o_count[0], 0);

        // FIFO fill, reject when full, wrap
        do_reset();
        for (int v = 1; v <= 4; v++) push_one(0, v * 10);
        chk("fifo.full", o_full[1], 1);
        rr[0] = 1'b1; din[0 +: W] = W'(99);
        tick();
        rr = '0;
        chk("fifo.noread", o_read[1], 0);
        tick();
        chk("fifo.cnt4", o_count[1], 4);
        take(1, 0, 2);
        for (int i = 0; i < got.size(); i++) chk("fifo.pop1", got[i], (i + 1) * 10);
        push_one(0, 50);
        push_one(0, 60);
        take(1, 0, 4);
        exp_f = '{30, 40, 50, 60};
        for (int i = 0; i < got.size(); i++) chk("fifo.pop2", got[i], exp_f[i]);

        // Push arbitration between ports 0 and 2
        do_reset();
        rr = 4'b0101;
        din[0*W +: W] = W'(100);
        din[2*W +: W] = W'(200);
        got.delete();
        got_cyc.delete();
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_read[0] != 0) begin
                got.push_back(o_read[0]);
                got_cyc.push_back(c);
            end
        end
        rr = '0;
        chk("arb.n", got.size(), 15);
        for (int i = 0; i < got.size(); i++) begin
            chk("arb.port", got[i], (i % 2 == 0) ? 1 : 4);
            chk("arb.cyc", got_cyc[i] - got_cyc[0], i);
        end
        chk("arb.count", o_count[0], 15);
        chk("arb.full", o_full[0], 1);

        // Round-robin offer on ports 1 and 3
        do_reset();
        push_one(1, 33);
        push_one(1, 44);
        wait_write(2);
        for (int i = 0; i < 4; i++) begin
            w[i] = o_write[2];
            tick();
        end
        for (int i = 0; i < 4; i++) chk("rr.onehot", $countones(w[i]), 1);
        for (int i = 0; i < 3; i++) chk("rr.alt", w[i] | w[i+1], 10);
        take(2, 3, 1);
        if (got.size() > 0) chk("rr.val", got[0], 44);
        chk("rr.count", o_count[2], 1);

        // Broadcast collision
        do_reset();
        push_one(0, 11'h7FB);
        push_one(0, 7);
        wait_write(0);
        wr = 4'b0011;
        tick();
        wr = '0;
        chk("col.flag", o_col[0], 1);
        chk("col.count", o_count[0], 1);
        wait_write(0);
        chk("col.next", o_out[0], 11'h7FB);
        tick();
        chk("col.sticky", o_col[0], 1);

        // Random traffic, with a reset dropped in mid-stream
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (c == 1500) do_reset();
            rr = N'($urandom_range(0, 15));
            for (int p = 0; p < N; p++) din[p*W +: W] = W'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 5)      wr = '0;
            else if (r <= 8) wr = N'(1) << $urandom_range(0, N - 1);
            else             wr = N'($urandom_range(0, 15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_node.md
# mem_node

Parametrised TIS memory node, the successor to the fixed 4-port stack node. It sits in the node grid beside `core` instances and uses the same neighbour handshake. It accepts values from any enabled neighbour and stores up to DEPTH entries in LIFO or FIFO order. It offers the top/head entry back to neighbours, either broadcast to all enabled ports or round-robin to one port at a time, and reports occupancy and protocol collisions.

## Interface
- DATA_W, 11: word width (two's complement, TIS range held unmodified)
- DEPTH, 15: entries; count is $clog2(DEPTH+1) bits
- NPORTS, 4: neighbour ports; index 0=up, 1=right, 2=down, 3=left
- PORT_MASK, all ones: bit d=1 enables port d for both push and pop
- QUEUE, 0: 0 = LIFO stack, 1 = FIFO queue
- RR_OFFER, 0: 0 = broadcast offer, 1 = one-hot round-robin offer
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rready  in  NPORTS  neighbour d offers in_data[d]
- in_data  in  NPORTS*DATA_W  neighbour values, port d at [d*DATA_W +: DATA_W]
- read  out  NPORTS  one-cycle pulse: value from port d consumed
- write  out  NPORTS  node offers `out` on port d
- wready  in  NPORTS  neighbour d took `out` this cycle
- out  out  DATA_W  top (LIFO) or head (FIFO) entry
- count  out  $clog2(DEPTH+1)  occupancy
- empty, full  out  1  count==0 / count==DEPTH
- collide  out  1  sticky: ≥2 wready bits seen in one cycle

## Operation
- Reset: storage pointers cleared, count=0, read=0, write=0, out=0, collide=0, rr pointers=0. Storage contents are don't-care. Reset mid-transfer discards the transfer; no read pulse is produced.
- Push arbitration: candidates are d with rready[d] & PORT_MASK[d] & ~read[d]. A port that was pulsed last cycle is blocked for one cycle so the neighbour can drop rready. If !full and any candidate exists, pick the first candidate at or after the push rr pointer. Capture in_data[d], pulse read[d] next cycle, and move the pointer to d+1 mod NPORTS. One push per cycle maximum.
- Offer: write is registered. When not empty and no pop occurred last cycle:
  - RR_OFFER=0: write = PORT_MASK.
  - RR_OFFER=1: write is one-hot on the offer pointer, which advances each cycle without transfer to the next enabled port.
- Pop: a transfer occurs when (wready & write) != 0. The node pops exactly once. If more than one bit is set, set collide; this is a system bug, and the node still pops once. In RR mode the offer pointer moves past the taken port.
- Simultaneous push and pop in one cycle:
  - LIFO: the presented top is removed and the pushed value becomes the new top.
  - FIFO: the head is removed and the value is appended at the tail.
  - Count is unchanged. Push is allowed when full only if a pop happens the same cycle.
- Pointer wrap: FIFO head/tail wrap modulo DEPTH. LIFO uses a single stack pointer, with no wrap.
- wready on a port whose write=0 is ignored.

## Timing
- Push latency: rready sampled at edge t; read[d] high during cycle t+1; the value is counted at t+1.
- Offer latency: first push at edge t gives out/write valid from cycle t+2. The write register reflects the count after edge t+1.
- After a pop at edge t, write=0 during cycle t+1 (bubble). The next entry is offered from t+2 if non-empty. A neighbour therefore never sees the same word twice.
- out holds the offered value while write≠0 and never changes without a pop or a LIFO push. A LIFO push changes out only while write is low, or with a bubble first.
- Sustained throughput: one push per cycle from rotating ports, one pop per 2 cycles.

## Test plan
- Reset/idle: rst 2 cycles, no rready → write=0, read=0, out=0, count=0, empty=1, collide=0.
- LIFO order: push 1, 2, 3 from port 3, then port 1 takes all → received 3, 2, 1 with a one-cycle bubble between each. Final count=0.
- FIFO + wrap, QUEUE=1, DEPTH=4: push 10, 20, 30, 40 (full=1, a 5th rready gets no read), pop 2, push 50, 60 → pops yield 30, 40, 50, 60.
- Push arbitration: rready on ports 0 and 2 held continuously with distinct values → read alternates 0, 2, 0, 2. Neither port is pulsed on consecutive cycles. Stops at full with count=DEPTH.
- RR offer, RR_OFFER=1, PORT_MASK=4'b1010: with one entry stored, write cycles 4'b0010, 4'b1000, 4'b0010… Port 3 wready → pop, count-1.
- Broadcast collision: two entries -5 (11'h7FB) then 7; wready on ports 0 and 1 in the same cycle → collide=1, count decreases by exactly 1, next offer = -5.
